// File: rtl/receiver.sv
// UART receive stage: 2-flop line synchroniser, 16x oversampled frame FSM,
// first-word-fall-through frame FIFO and 1 ms low-line configuration detector.
module receiver #(
  parameter int RX_FIFO_DEPTH = 8,
  parameter int COUNT_1MS     = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable,
  input  logic       ov_baud_rt_i,
  input  logic       rx_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] stop_bits_number_i,
  input  logic [1:0] parity_mode_i,
  input  logic       rx_fifo_read_i,
  input  logic       clear_overrun_i,
  output logic [7:0] rx_data_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       rx_fifo_empty_o,
  output logic       rx_fifo_full_o,
  output logic       rx_done_o,
  output logic       overrun_o,
  output logic       config_req_slv_o,
  output logic       rx_idle_o
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int LW = $clog2(COUNT_1MS + 1);
  localparam logic [LW-1:0] LOW_MAX = LW'(COUNT_1MS);
  localparam logic [LW-1:0] LOW_HIT = LW'(COUNT_1MS - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(RX_FIFO_DEPTH);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_CFG_WAIT
  } rx_state_t;

  rx_state_t state, next_state;

  logic s1, rxs;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1  <= 1'b1;
      rxs <= 1'b1;
    end else begin
      s1  <= rx_i;
      rxs <= s1;
    end
  end

  // Saturating low-line counter: exactly one request pulse per low period.
  logic [LW-1:0] low_cnt;
  logic          cfg_hit;
  assign cfg_hit = !rxs && (low_cnt == LOW_HIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      low_cnt          <= '0;
      config_req_slv_o <= 1'b0;
    end else begin
      config_req_slv_o <= cfg_hit;
      if (rxs) low_cnt <= '0;
      else if (low_cnt != LOW_MAX) low_cnt <= low_cnt + 1'b1;
    end
  end

  logic [3:0] bit_cnt;
  logic [2:0] bit_idx;
  logic       stop_idx;
  logic [7:0] shreg;
  logic [1:0] wcode;
  logic       par_en, par_odd, two_stop;
  logic       parity_err_r, frame_err_r;
  logic       sample, push;
  logic [7:0] data_out;
  logic [9:0] push_entry;

  // Start is checked at half a bit; every later sample lands mid-bit.
  assign sample     = ov_baud_rt_i && (bit_cnt == ((state == RX_START) ? 4'd7 : 4'd15));
  assign data_out   = shreg >> (2'd3 - wcode);
  assign push_entry = {frame_err_r | !rxs, parity_err_r, data_out};

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= RX_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    push       = 1'b0;
    unique case (state)
      RX_IDLE:     if (enable && !rxs) next_state = RX_START;
      RX_START:    if (sample) next_state = rxs ? RX_IDLE : RX_DATA;
      RX_DATA:     if (sample && (bit_idx == (3'd4 + {1'b0, wcode})))
                     next_state = par_en ? RX_PARITY : RX_STOP;
      RX_PARITY:   if (sample) next_state = RX_STOP;
      RX_STOP:     if (sample && (!two_stop || stop_idx)) begin
                     next_state = RX_IDLE;
                     push       = 1'b1;
                   end
      RX_CFG_WAIT: if (rxs) next_state = RX_IDLE;
      default:     next_state = RX_IDLE;
    endcase
    if (cfg_hit) begin
      next_state = RX_CFG_WAIT;
      push       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt      <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shreg        <= '0;
      wcode        <= '0;
      par_en       <= 1'b0;
      par_odd      <= 1'b0;
      two_stop     <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      if (state == RX_IDLE) bit_cnt <= '0;
      else if (sample && state == RX_START) bit_cnt <= '0;
      else if (ov_baud_rt_i) bit_cnt <= bit_cnt + 1'b1;

      unique case (state)
        RX_START: if (sample && !rxs) begin
          wcode        <= data_width_i;
          par_en       <= !parity_mode_i[1];
          par_odd      <= parity_mode_i[0];
          two_stop     <= (stop_bits_number_i == 2'b01);
          shreg        <= '0;
          bit_idx      <= '0;
          stop_idx     <= 1'b0;
          parity_err_r <= 1'b0;
          frame_err_r  <= 1'b0;
        end
        RX_DATA: if (sample) begin
          shreg   <= {rxs, shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
        end
        RX_PARITY: if (sample) parity_err_r <= (^shreg) ^ rxs ^ par_odd;
        RX_STOP: if (sample) begin
          if (!rxs) frame_err_r <= 1'b1;
          stop_idx <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic [9:0]    mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_pop, do_write, ov_new;
  logic [9:0]    head;

  assign rx_fifo_empty_o = (count == '0);
  assign rx_fifo_full_o  = (count == DEPTH_C);
  assign do_pop          = rx_fifo_read_i && !rx_fifo_empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_write        = push && (!rx_fifo_full_o || do_pop);
  assign ov_new          = push && rx_fifo_full_o && !do_pop;

  always_ff @(posedge clk_i) begin
    if (do_write) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_o <= 1'b0;
      rx_done_o <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_write, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      overrun_o <= (overrun_o && !clear_overrun_i) || ov_new;
      rx_done_o <= do_write;
    end
  end

  assign head         = mem[rd_ptr];
  assign rx_data_o    = rx_fifo_empty_o ? 8'h00 : head[7:0];
  assign parity_err_o = rx_fifo_empty_o ? 1'b0  : head[8];
  assign frame_err_o  = rx_fifo_empty_o ? 1'b0  : head[9];
  assign rx_idle_o    = (state == RX_IDLE);

endmodule
